// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, register-file write and decode hazard signals shared by the
// writeback arbiter and its neighbours.
interface regfile_wb_arbiter_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG_W = 5
);
  logic [2:0]          req_valid;
  logic [2:0]          req_ready;
  logic [3*NREG_W-1:0] req_rd;
  logic [3*XLEN-1:0]   req_data;

  logic                wb_valid;
  logic [NREG_W-1:0]   wb_rd;
  logic [XLEN-1:0]     wb_data;

  logic                issue_valid;
  logic [NREG_W-1:0]   issue_rd;
  logic                issue_ready;
  logic [NREG_W-1:0]   rs1_idx;
  logic [NREG_W-1:0]   rs2_idx;
  logic                rs1_busy;
  logic                rs2_busy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_rd, req_data, issue_valid, issue_rd, rs1_idx, rs2_idx,
    output req_ready, wb_valid, wb_rd, wb_data, issue_ready, rs1_busy, rs2_busy
  );

  // Execute/decode/register-file side.
  modport master (
    output req_valid, req_rd, req_data, issue_valid, issue_rd, rs1_idx, rs2_idx,
    input  req_ready, wb_valid, wb_rd, wb_data, issue_ready, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU, LSU and
// MULDIV, with a registered write stage and a per-register busy scoreboard.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG_W = 5
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned NReg = 1 << NREG_W;

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [2:0]        req_rot;
  logic [1:0]        gnt_off;
  logic [2:0]        gnt_sum;
  logic              gnt_vld;
  logic [1:0]        gnt_idx;
  logic [NREG_W-1:0] gnt_rd;
  logic [XLEN-1:0]   gnt_data;

  logic              wb_valid_q, wb_valid_d;
  logic [NREG_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  logic [NReg-1:0]   busy_q, busy_d;
  logic              issue_ok;

  // Rotate requests so bit 0 is the source currently holding priority.
  always_comb begin
    case (rr_ptr_q)
      2'd1:    req_rot = {bus.req_valid[0], bus.req_valid[2:1]};
      2'd2:    req_rot = {bus.req_valid[1:0], bus.req_valid[2]};
      default: req_rot = bus.req_valid;
    endcase
  end

  always_comb begin
    gnt_vld = |req_rot;
    if (req_rot[0]) begin
      gnt_off = 2'd0;
    end else if (req_rot[1]) begin
      gnt_off = 2'd1;
    end else begin
      gnt_off = 2'd2;
    end
    gnt_sum = {1'b0, rr_ptr_q} + {1'b0, gnt_off};
    gnt_idx = (gnt_sum >= 3'd3) ? 2'(gnt_sum - 3'd3) : gnt_sum[1:0];
  end

  always_comb begin
    case (gnt_idx)
      2'd1: begin
        gnt_rd   = bus.req_rd[2*NREG_W-1:NREG_W];
        gnt_data = bus.req_data[2*XLEN-1:XLEN];
      end
      2'd2: begin
        gnt_rd   = bus.req_rd[3*NREG_W-1:2*NREG_W];
        gnt_data = bus.req_data[3*XLEN-1:2*XLEN];
      end
      default: begin
        gnt_rd   = bus.req_rd[NREG_W-1:0];
        gnt_data = bus.req_data[XLEN-1:0];
      end
    endcase
  end

  assign bus.req_ready = gnt_vld ? (3'b001 << gnt_idx) : 3'b000;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (gnt_vld) begin
      // x0 writes are consumed but never reach the register file.
      wb_valid_d = (gnt_rd != '0);
      wb_rd_d    = gnt_rd;
      wb_data_d  = gnt_data;
      rr_ptr_d   = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q   <= 2'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;

  assign issue_ok        = ~busy_q[bus.issue_rd];
  assign bus.issue_ready = issue_ok;
  assign bus.rs1_busy    = busy_q[bus.rs1_idx];
  assign bus.rs2_busy    = busy_q[bus.rs2_idx];

  // Clear lands on the same edge the register file captures the data; a same-index
  // set is applied afterwards so it wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_q && (wb_rd_q != '0)) begin
      busy_d[wb_rd_q] = 1'b0;
    end
    if (bus.issue_valid && issue_ok && (bus.issue_rd != '0)) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifndef SYNTHESIS
  a_rr_ptr_legal : assert property (@(posedge clk) disable iff (!rst) rr_ptr_q != 2'd3);
  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.req_ready));
  a_ready_valid  : assert property (@(posedge clk) disable iff (!rst)
                                    (bus.req_ready & ~bus.req_valid) == 3'b000);
  a_x0_never_busy : assert property (@(posedge clk) disable iff (!rst) !busy_q[0]);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter with a queue-based writeback
// scoreboard and a behavioural arbitration/scoreboard model.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst;

  regfile_wb_arbiter_if #(.XLEN(32), .NREG_W(5)) bus ();

  regfile_wb_arbiter #(.XLEN(32), .NREG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          rd;
    logic [31:0] data;
    int          cyc;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // Reference model state.
  int  m_ptr = 0;
  bit  m_busy[32];
  int  m_pend_rd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle, wb_valid must match whether a write is due now.
  always @(negedge clk) begin
    if (rst) begin
      logic due;
      wb_t  e;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("wb_valid", 64'(bus.wb_valid), 64'(due));
      if (due && bus.wb_valid) begin
        e = exp_q.pop_front();
        chk("wb_rd", 64'(bus.wb_rd), 64'(e.rd));
        chk("wb_data", 64'(bus.wb_data), 64'(e.data));
      end
    end
  end

  task automatic model_reset();
    m_ptr = 0;
    m_pend_rd = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    exp_q.delete();
  endtask

  task automatic step(input logic [2:0] rv,
                      input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] s1, input logic [4:0] s2);
    int          g;
    int          rds[3];
    logic [31:0] dat[3];
    logic        exp_iready;
    @(negedge clk);
    bus.req_valid   = rv;
    bus.req_rd      = {r2, r1, r0};
    bus.req_data    = {d2, d1, d0};
    bus.issue_valid = iv;
    bus.issue_rd    = ird;
    bus.rs1_idx     = s1;
    bus.rs2_idx     = s2;
    rds = '{int'(r0), int'(r1), int'(r2)};
    dat = '{d0, d1, d2};
    #1;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      if (g < 0 && rv[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
    end
    exp_iready = (ird == 5'd0) || !m_busy[ird];
    chk("req_ready", 64'(bus.req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
    chk("issue_ready", 64'(bus.issue_ready), 64'(exp_iready));
    chk("rs1_busy", 64'(bus.rs1_busy), 64'(m_busy[s1]));
    chk("rs2_busy", 64'(bus.rs2_busy), 64'(m_busy[s2]));
    // State after the coming edge: retire last cycle's write, then apply the issue.
    if (m_pend_rd != 0) m_busy[m_pend_rd] = 1'b0;
    if (iv && exp_iready && ird != 5'd0) m_busy[ird] = 1'b1;
    m_pend_rd = 0;
    if (g >= 0) begin
      m_ptr = (g + 1) % 3;
      if (rds[g] != 0) begin
        m_pend_rd = rds[g];
        exp_q.push_back('{rd: rds[g], data: dat[g], cyc: cyc + 1});
      end
    end
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, s1, s2);
  endtask

  task automatic zero_inputs();
    bus.req_valid   = 3'b000;
    bus.req_rd      = '0;
    bus.req_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.rs1_idx     = '0;
    bus.rs2_idx     = '0;
  endtask

  task automatic rand_step();
    step(3'($urandom_range(0, 7)),
         5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
         $urandom, $urandom, $urandom,
         1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
         5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
  endtask

  initial begin
    zero_inputs();
    rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
    chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("rst_rs1_busy", 64'(bus.rs1_busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Full contention from reset: grants rotate 0,1,2,0,1,2.
    for (int i = 0; i < 6; i++) begin
      step(3'b111, 5'd1, 5'd2, 5'd3, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i),
           32'hC000_0000 + 32'(i), 1'b0, 5'd0, 5'd0, 5'd0);
    end
    idle(5'd0, 5'd0);

    // Single ALU write.
    step(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // RAW/WAW on x7 resolved by an LSU writeback.
    step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0);
    step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    step(3'b010, 5'd0, 5'd7, 5'd0, 32'd0, 32'h7777_7777, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    idle(5'd7, 5'd0);
    step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd7);

    // MULDIV write to x0 and an x0 issue.
    step(3'b100, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h1234, 1'b1, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Clear of x3 and set of x9 on the same edge.
    step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0);
    step(3'b001, 5'd3, 5'd0, 5'd0, 32'h3333, 32'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
    step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd9, 5'd3, 5'd9);
    idle(5'd3, 5'd9);

    for (int i = 0; i < 400; i++) rand_step();

    // Reset in the middle of a write with x12 busy.
    step(3'b001, 5'd20, 5'd0, 5'd0, 32'hCAFE_F00D, 32'd0, 32'd0, 1'b1, 5'd12, 5'd0, 5'd0);
    @(posedge clk);
    #2;
    zero_inputs();
    bus.rs1_idx = 5'd12;
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("midrst_wb_rd", 64'(bus.wb_rd), 64'd0);
    chk("midrst_wb_data", 64'(bus.wb_data), 64'd0);
    chk("midrst_rs1_busy", 64'(bus.rs1_busy), 64'd0);
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("midrst_issue_ready", 64'(bus.issue_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 200; i++) rand_step();
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (rd / data_des / data_valid) between three writeback sources: ALU, load unit, mul/div unit.
- Uses a round-robin arbiter with a registered output stage.
- Keeps a 32-entry busy scoreboard so decode can detect RAW and WAW hazards on x1–x31.
- Sits between the execute/memory stages and the register file, and feeds stall signals back to decode.

Parameters:
XLEN, 32, data width of writeback and register-file data
NREG_W, 5, register index width (32 architectural registers)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  3  per-source writeback request; bit0 ALU, bit1 LSU, bit2 MULDIV
req_ready  output  3  per-source grant; a transfer occurs when req_valid[i] & req_ready[i]
req_rd  input  3*NREG_W  destination index per source, source i at bits [5i+4:5i]
req_data  input  3*XLEN  result data per source, source i at bits [32i+31:32i]
wb_valid  output  1  drives register-file data_valid
wb_rd  output  NREG_W  drives register-file rd
wb_data  output  XLEN  drives register-file data_des
issue_valid  input  1  decode wants to issue an instruction that writes issue_rd
issue_rd  input  NREG_W  destination of the issuing instruction
issue_ready  output  1  issue allowed this cycle (no WAW)
rs1_idx  input  NREG_W  decode source 1 index
rs2_idx  input  NREG_W  decode source 2 index
rs1_busy  output  1  source 1 has a pending write (RAW stall)
rs2_busy  output  1  source 2 has a pending write (RAW stall)

Behaviour:
- Reset: while rst=0, asynchronously clear the following:
  - wb_valid=0, wb_rd=0, wb_data=0
  - rr_ptr=0
  - busy[31:0]=0
  - Combinational outputs then evaluate to req_ready=000, issue_ready=1, rs1_busy=rs2_busy=0.
  - Reset asserted mid-transfer drops any in-flight write; nothing is replayed.
- Arbitration (combinational):
  - rr_ptr is 2 bits, legal values 0..2.
  - Search order is rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). The first asserted req_valid wins.
  - At most one req_ready bit is high, and only for a valid requester. req_ready may depend on req_valid.
  - On a grant to source g, rr_ptr <= (g+1) mod 3. With no grant, rr_ptr holds.
- Output stage (1-cycle latency):
  - On a grant in cycle N: wb_valid=1, wb_rd=req_rd[g], wb_data=req_data[g] in cycle N+1.
  - With no grant: wb_valid=0; wb_rd and wb_data hold their previous values.
  - A grant with req_rd=0 is accepted (ready=1) but produces wb_valid=0 in N+1. x0 is never written.
  - Back-to-back grants every cycle are allowed. The arbiter never stalls on its output.
- Scoreboard:
  - Set: issue_valid & issue_ready & issue_rd!=0 sets busy[issue_rd] at the clock edge.
  - Clear: wb_valid & wb_rd!=0 clears busy[wb_rd] at the edge that ends the wb_valid cycle, the same edge at which the register file captures the data. The bit therefore reads 0 exactly when the register file holds the new value.
  - Same index set and cleared in the same cycle: set wins. This case is only reachable when issue_ready was 1, i.e. busy was already clear.
  - busy[0] is constantly 0.
  - issue_ready = ~busy[issue_rd]. It is 1 when issue_rd=0.
  - rs1_busy = busy[rs1_idx]; rs2_busy = busy[rs2_idx]. Both are combinational from registered state; no bypass through wb_valid.
- Requests for an index with no busy bit set are still written (no checking); the scoreboard bit stays 0.

Test Plan:
- Reset with all inputs 0 -> wb_valid=0, issue_ready=1, rs1_busy=0, req_ready=000; assert rst=0 mid-burst -> outputs clear immediately, without a clock edge.
- Single ALU request, rd=5, data=0xDEADBEEF in cycle N -> req_ready=001 in N; wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF in N+1; wb_valid=0 in N+2.
- req_valid=111 held 6 cycles from reset -> grants 0,1,2,0,1,2; wb_rd sequence follows the matching sources.
- Issue rd=7 -> rs1_idx=7 gives rs1_busy=1 the next cycle; second issue rd=7 sees issue_ready=0; LSU writeback rd=7 -> busy clears at the end of the wb_valid cycle, after which rs1_busy=0 and issue_ready=1.
- MULDIV request with rd=0, data=0x1234 -> req_ready=100, wb_valid stays 0, busy unchanged; issue_rd=0 keeps issue_ready=1 with no bit set.
- Writeback for rd=3 in the same cycle as a new issue rd=9 -> busy[3] clears and busy[9] sets in the same edge; rs1_idx=3 and rs2_idx=9 show 0 and 1 respectively.
